// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline sequencer: control FSM states, the
// bundled per-stage load/flush word, and the load-use hazard test.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic load;
    logic flush;
  } stage_ctl_t;

  typedef struct packed {
    stage_ctl_t if_id;
    stage_ctl_t id_ex;
    stage_ctl_t ex_mem;
    stage_ctl_t mem_wb;
  } pipe_ctl_t;

  localparam pipe_ctl_t PIPE_CTL_IDLE = '0;

  localparam int unsigned NUM_PERF    = 3;
  localparam int unsigned PERF_STALL  = 0;
  localparam int unsigned PERF_FLUSH  = 1;
  localparam int unsigned PERF_MISPRED = 2;

  localparam logic [4:0] REG_X0 = 5'd0;

  // x0 is hardwired to zero, so a load "into" x0 never creates a dependency.
  function automatic logic load_use(input logic       is_load,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return is_load && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running wrap-around event counter with synchronous clear that
// outranks the increment.
module pipeline_hazard_ctrl_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: arbitrates cache freezes, load-use
// bubbles and EX redirects, and keeps stall/flush/mispredict counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             perf_clr,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  pipe_state_e state_reg, state_next;
  logic [31:0] target_reg, target_next;

  pipe_ctl_t ctl_next;
  logic      load_pc_next;
  logic      pc_redirect_next;
  logic      accept_next;

  logic imiss, dmiss, lu;

  assign imiss = imem_req & ~imem_resp;
  assign dmiss = dmem_req & ~dmem_resp;
  assign lu    = load_use(ex_is_load, ex_rd, id_rs1, id_rs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_RUN;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    target_next      = target_reg;
    ctl_next         = PIPE_CTL_IDLE;
    load_pc_next     = 1'b0;
    pc_redirect_next = 1'b0;
    accept_next      = 1'b0;
    redirect_pc      = (state_reg == ST_DRAIN) ? target_reg : ex_target;

    unique case (state_reg)
      ST_RUN: begin
        if (dmiss) begin
          // Full freeze; the frozen ID/EX keeps any pending redirect stable.
        end else if (ex_redirect && !imiss) begin
          load_pc_next         = 1'b1;
          ctl_next.if_id.load  = 1'b1;
          ctl_next.if_id.flush = 1'b1;
          ctl_next.id_ex.load  = 1'b1;
          ctl_next.id_ex.flush = 1'b1;
          ctl_next.ex_mem.load = 1'b1;
          ctl_next.mem_wb.load = 1'b1;
          pc_redirect_next     = 1'b1;
          accept_next          = 1'b1;
        end else if (ex_redirect && imiss) begin
          // The outstanding fetch cannot be cancelled: remember the target
          // and apply it once the wrong-path word has come back.
          target_next          = ex_target;
          ctl_next.id_ex.load  = 1'b1;
          ctl_next.id_ex.flush = 1'b1;
          ctl_next.ex_mem.load = 1'b1;
          ctl_next.mem_wb.load = 1'b1;
          accept_next          = 1'b1;
          state_next           = ST_DRAIN;
        end else if (imiss) begin
          // Full freeze until the I-cache answers.
        end else if (lu) begin
          ctl_next.id_ex.load  = 1'b1;
          ctl_next.id_ex.flush = 1'b1;
          ctl_next.ex_mem.load = 1'b1;
          ctl_next.mem_wb.load = 1'b1;
        end else begin
          load_pc_next         = 1'b1;
          ctl_next.if_id.load  = 1'b1;
          ctl_next.id_ex.load  = 1'b1;
          ctl_next.ex_mem.load = 1'b1;
          ctl_next.mem_wb.load = 1'b1;
        end
      end

      ST_DRAIN: begin
        // EX holds only bubbles here, so ex_redirect is deliberately ignored.
        if (!dmiss) begin
          ctl_next.id_ex.load  = 1'b1;
          ctl_next.id_ex.flush = 1'b1;
          ctl_next.ex_mem.load = 1'b1;
          ctl_next.mem_wb.load = 1'b1;
          if (imem_resp) begin
            load_pc_next         = 1'b1;
            pc_redirect_next     = 1'b1;
            ctl_next.if_id.load  = 1'b1;
            ctl_next.if_id.flush = 1'b1;
            state_next           = ST_RUN;
          end
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Strobes are held low for the whole time reset is asserted.
  assign load_pc     = rst_n & load_pc_next;
  assign load_if_id  = rst_n & ctl_next.if_id.load;
  assign load_id_ex  = rst_n & ctl_next.id_ex.load;
  assign load_ex_mem = rst_n & ctl_next.ex_mem.load;
  assign load_mem_wb = rst_n & ctl_next.mem_wb.load;
  assign flush_if_id = rst_n & ctl_next.if_id.flush;
  assign flush_id_ex = rst_n & ctl_next.id_ex.flush;
  assign pc_redirect = rst_n & pc_redirect_next;

  logic [NUM_PERF-1:0] perf_inc;
  logic [CNT_W-1:0]    perf_val [NUM_PERF];

  assign perf_inc[PERF_STALL]   = ~load_pc_next;
  assign perf_inc[PERF_FLUSH]   = ctl_next.if_id.flush | ctl_next.id_ex.flush |
                                  ctl_next.ex_mem.flush | ctl_next.mem_wb.flush;
  assign perf_inc[PERF_MISPRED] = accept_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PERF; gi++) begin : g_perf
      pipeline_hazard_ctrl_perf_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (perf_inc[gi]),
        .clr   (perf_clr),
        .count (perf_val[gi])
      );
    end
  endgenerate

  assign stall_cnt   = perf_val[PERF_STALL];
  assign flush_cnt   = perf_val[PERF_FLUSH];
  assign mispred_cnt = perf_val[PERF_MISPRED];

endmodule
